// File: rtl/line_mem_arbiter_if.sv
// Cache line-fill/writeback ports and the shared burst memory port of line_mem_arbiter.
// slave is the arbiter side; master is the side driving the requests and the memory responses.
interface line_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
);
    localparam int LINE_W = BEAT_W * BEATS;

    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [BEAT_W-1:0] mem_wdata;
    logic [BEAT_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between the I-cache and D-cache,
// sequencing each granted line as a BEATS-beat burst and pulsing a one-cycle completion.
module line_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    line_mem_arbiter_if.slave bus
);
    localparam int LINE_W = BEAT_W * BEATS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE_I,
        DONE_D
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wbuf;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              i_resp_q;
    logic              d_resp_q;

    logic i_pend;
    logic d_pend;
    logic pick_d;
    logic unused_addr_bits;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    function automatic logic [LINE_W-1:0] put_beat(input logic [LINE_W-1:0] line,
                                                   input logic [CNT_W-1:0]  idx,
                                                   input logic [BEAT_W-1:0] beat);
        logic [LINE_W-1:0] r;
        r = line;
        r[int'(idx)*BEAT_W +: BEAT_W] = beat;
        return r;
    endfunction

    function automatic logic [BEAT_W-1:0] get_beat(input logic [LINE_W-1:0] line,
                                                   input logic [CNT_W-1:0]  idx);
        return line[int'(idx)*BEAT_W +: BEAT_W];
    endfunction

    // On a tie the side that did not win last time is granted.
    always_comb begin
        i_pend = bus.i_read;
        d_pend = bus.d_read | bus.d_write;
        pick_d = d_pend & (~i_pend | (last_grant == GRANT_I));
    end

    // Byte offset within a line is discarded by design.
    assign unused_addr_bits = ^{bus.i_addr[OFF_W-1:0], bus.d_addr[OFF_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= GRANT_D;
            addr_q      <= '0;
            wbuf        <= '0;
            line_buf    <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_d) begin
                        last_grant <= GRANT_D;
                        addr_q     <= line_align(bus.d_addr);
                        // A dirty writeback always goes out before the fill.
                        if (bus.d_write) begin
                            wbuf        <= bus.d_wdata;
                            mem_write_q <= 1'b1;
                            state       <= D_WR;
                        end else begin
                            mem_read_q <= 1'b1;
                            state      <= D_RD;
                        end
                    end else if (i_pend) begin
                        last_grant <= GRANT_I;
                        addr_q     <= line_align(bus.i_addr);
                        mem_read_q <= 1'b1;
                        state      <= I_RD;
                    end
                end

                I_RD, D_RD: begin
                    if (bus.mem_resp) begin
                        if (cnt == LAST_BEAT) begin
                            mem_read_q <= 1'b0;
                            cnt        <= '0;
                            if (state == I_RD) begin
                                i_rdata_q <= put_beat(line_buf, cnt, bus.mem_rdata);
                                i_resp_q  <= 1'b1;
                                state     <= DONE_I;
                            end else begin
                                d_rdata_q <= put_beat(line_buf, cnt, bus.mem_rdata);
                                d_resp_q  <= 1'b1;
                                state     <= DONE_D;
                            end
                        end else begin
                            line_buf <= put_beat(line_buf, cnt, bus.mem_rdata);
                            cnt      <= cnt + CNT_W'(1);
                        end
                    end
                end

                D_WR: begin
                    if (bus.mem_resp) begin
                        if (cnt == LAST_BEAT) begin
                            mem_write_q <= 1'b0;
                            cnt         <= '0;
                            d_resp_q    <= 1'b1;
                            state       <= DONE_D;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                DONE_I: begin
                    i_resp_q <= 1'b0;
                    state    <= IDLE;
                end

                DONE_D: begin
                    d_resp_q <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = (state == D_WR) ? get_beat(wbuf, cnt) : '0;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_resp    = i_resp_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_resp    = d_resp_q;
endmodule

// File: tb/tb_line_mem_arbiter.sv
// Bench for line_mem_arbiter: a burst memory responder with programmable beat latency,
// a line-level reference model, table-driven vectors, corner sequences and random traffic.
module tb_line_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int LINE_W = BEAT_W * BEATS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_mem_arbiter_if #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) bus ();

    line_mem_arbiter #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] pattern(input logic [31:0] ba);
        return {ba ^ 32'hA5A5_0000, ~ba};
    endfunction

    // ---------------- memory responder ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
    } burst_t;

    int          mem_lat     = 0;
    int          wait_cnt    = 0;
    int          beat_k      = 0;
    int          beats_given = 0;
    bit          spurious    = 1'b0;
    logic [31:0] cur_addr    = '0;
    logic [BEAT_W-1:0] mem_img [logic [31:0]];
    burst_t      burst_q[$];
    logic [BEAT_W-1:0] wr_q[$];

    initial begin
        logic [31:0] ba;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_resp = 1'b0;
            if (bus.mem_read || bus.mem_write) begin
                chk("mem_rd_wr_exclusive", {255'b0, bus.mem_read & bus.mem_write}, '0);
                if (beat_k == 0 && wait_cnt == 0) cur_addr = bus.mem_addr;
                else chk("mem_addr_stable", bus.mem_addr, cur_addr);
                if (wait_cnt >= mem_lat) begin
                    wait_cnt = 0;
                    ba = cur_addr + 32'(8 * beat_k);
                    if (beat_k == 0) burst_q.push_back('{cur_addr, bus.mem_write});
                    if (bus.mem_write) begin
                        mem_img[ba] = bus.mem_wdata;
                        wr_q.push_back(bus.mem_wdata);
                    end else begin
                        bus.mem_rdata = mem_img.exists(ba) ? mem_img[ba] : pattern(ba);
                    end
                    bus.mem_resp = 1'b1;
                    beats_given++;
                    beat_k = (beat_k == BEATS - 1) ? 0 : beat_k + 1;
                end else begin
                    wait_cnt++;
                end
            end else begin
                beat_k   = 0;
                wait_cnt = 0;
                if (spurious) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [BEAT_W-1:0] ref_img [logic [31:0]];
    int ref_last = 1;  // 0 = I, 1 = D

    function automatic logic [LINE_W-1:0] ref_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        logic [31:0] ba;
        for (int k = 0; k < BEATS; k++) begin
            ba = la + 32'(8 * k);
            l[k*BEAT_W +: BEAT_W] = ref_img.exists(ba) ? ref_img[ba] : pattern(ba);
        end
        return l;
    endfunction

    function automatic int model_first(input bit ri, input bit dp);
        if (ri && dp) return (ref_last == 1) ? 0 : 1;
        return ri ? 0 : 1;
    endfunction

    task automatic model_update(input bit ri, input bit dp, input int first);
        if (ri && dp) ref_last = 1 - first;
        else ref_last = ri ? 0 : 1;
    endtask

    // Presents one set of simultaneous requests and follows them to completion.
    task automatic run_set(input bit ri, input bit rd, input bit wd,
                           input logic [31:0] ai, input logic [31:0] ad,
                           input logic [LINE_W-1:0] wdat, input int lat,
                           output int first, output int nresp);
        logic [LINE_W-1:0] exp_i, exp_d;
        logic [31:0] la_i, la_d;
        bit pend_i, pend_d;
        int cyc;
        int order[$];
        la_i  = {ai[31:5], 5'b0};
        la_d  = {ad[31:5], 5'b0};
        exp_i = ref_line(la_i);
        exp_d = ref_line(la_d);
        if (wd) for (int k = 0; k < BEATS; k++) ref_img[la_d + 32'(8*k)] = wdat[k*BEAT_W +: BEAT_W];
        mem_lat = lat;
        burst_q.delete();
        wr_q.delete();
        @(negedge clk);
        bus.i_read  = ri;
        bus.i_addr  = ai;
        bus.d_read  = rd;
        bus.d_write = wd;
        bus.d_addr  = ad;
        bus.d_wdata = wdat;
        pend_i = ri;
        pend_d = rd | wd;
        first  = -1;
        nresp  = 0;
        cyc    = 0;
        while ((pend_i || pend_d) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (bus.i_resp) begin
                nresp++;
                if (first < 0) first = 0;
                order.push_back(0);
                chk("i_resp_while_pending", {255'b0, pend_i}, 1);
                chk("i_rdata", bus.i_rdata, exp_i);
                pend_i = 1'b0;
                bus.i_read = 1'b0;
            end
            if (bus.d_resp) begin
                nresp++;
                if (first < 0) first = 1;
                order.push_back(1);
                chk("d_resp_while_pending", {255'b0, pend_d}, 1);
                if (!wd) chk("d_rdata", bus.d_rdata, exp_d);
                pend_d = 1'b0;
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end
        end
        if (pend_i || pend_d) begin
            chk("completion_timeout", {254'b0, pend_i, pend_d}, '0);
            bus.i_read  = 1'b0;
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
        end
        if (ri != (rd || wd)) chk("single_latency", cyc, 1 + BEATS * (lat + 1));
        chk("burst_count", burst_q.size(), order.size());
        for (int k = 0; k < order.size(); k++) begin
            if (k < burst_q.size()) begin
                chk("burst_addr", burst_q[k].addr, order[k] == 0 ? la_i : la_d);
                chk("burst_kind", {255'b0, burst_q[k].wr}, (order[k] == 1) && wd);
            end
        end
        chk("write_beats", wr_q.size(), wd ? BEATS : 0);
        for (int k = 0; k < wr_q.size() && k < BEATS; k++)
            chk("mem_wdata_beat", wr_q[k], wdat[k*BEAT_W +: BEAT_W]);
        @(negedge clk);
        chk("resp_single_cycle", {254'b0, bus.i_resp, bus.d_resp}, '0);
        if (ri) chk("i_rdata_held", bus.i_rdata, exp_i);
    endtask

    typedef struct {
        bit ri;
        bit rd;
        bit wd;
        logic [31:0] ai;
        logic [31:0] ad;
        logic [LINE_W-1:0] wdat;
        int lat;
        int exp_first;
        int exp_n;
    } vec_t;

    vec_t vecs[7];
    localparam logic [LINE_W-1:0] LINE0 =
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    localparam logic [LINE_W-1:0] WLINE =
        256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;

    initial begin
        int f, n, cyc, base;
        bit ri, rd, wd, saw;
        logic [31:0] ai, ad;
        logic [LINE_W-1:0] wdat, l0;

        bus.i_read  = 1'b0;
        bus.i_addr  = '0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        l0 = LINE0;
        for (int k = 0; k < BEATS; k++) begin
            ref_img[32'h60 + 32'(8*k)] = l0[k*BEAT_W +: BEAT_W];
            mem_img[32'h60 + 32'(8*k)] = l0[k*BEAT_W +: BEAT_W];
        end

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0064, 32'h0,          '0,    0, 0, 1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0,          32'h0000_0080, WLINE, 0, 1, 1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0001_0000, '0,    0, 0, 2};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_1020, 32'h0,          '0,    1, 0, 1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_2040, 32'h0001_0000, '0,    2, 1, 2};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0,          32'h0001_0047, ~WLINE, 0, 1, 1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_007f, 32'h0001_0040, {4{64'hCAFE_F00D_1234_5678}}, 1, 0, 2};

        repeat (3) @(negedge clk);
        chk("reset_mem_read",  {255'b0, bus.mem_read},  '0);
        chk("reset_mem_write", {255'b0, bus.mem_write}, '0);
        chk("reset_resp",      {254'b0, bus.i_resp, bus.d_resp}, '0);
        chk("reset_i_rdata",   bus.i_rdata, '0);
        chk("reset_d_rdata",   bus.d_rdata, '0);
        rst = 1'b0;
        ref_last = 1;

        for (int v = 0; v < 7; v++) begin
            run_set(vecs[v].ri, vecs[v].rd, vecs[v].wd, vecs[v].ai, vecs[v].ad,
                    vecs[v].wdat, vecs[v].lat, f, n);
            chk("vec_first_grant", f, vecs[v].exp_first);
            chk("vec_resp_count", n, vecs[v].exp_n);
            model_update(vecs[v].ri, vecs[v].rd | vecs[v].wd, f);
            if (v == 1) chk("i_rdata_held_over_write", bus.i_rdata, LINE0);
        end

        // Long stalls between beats.
        run_set(1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0, '0, 100, f, n);
        chk("stall_resp_count", n, 1);
        model_update(1'b1, 1'b0, f);

        // Stray mem_resp while idle must be ignored.
        spurious = 1'b1;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.i_resp || bus.d_resp || bus.mem_read || bus.mem_write) saw = 1'b1;
        end
        spurious = 1'b0;
        chk("idle_ignores_mem_resp", {255'b0, saw}, '0);
        run_set(1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0, '0, 0, f, n);
        chk("after_spurious_first", f, 0);
        model_update(1'b1, 1'b0, f);

        // Reset in the middle of a read burst.
        mem_lat = 0;
        @(negedge clk);
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0300;
        base = beats_given;
        cyc  = 0;
        while (beats_given - base < 2 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("abort_two_beats_seen", {255'b0, (beats_given - base) >= 2}, 1);
        @(negedge clk);
        rst = 1'b1;
        bus.i_read = 1'b0;
        @(negedge clk);
        chk("abort_mem_read",  {255'b0, bus.mem_read},  '0);
        chk("abort_mem_write", {255'b0, bus.mem_write}, '0);
        chk("abort_i_rdata",   bus.i_rdata, '0);
        chk("abort_d_rdata",   bus.d_rdata, '0);
        rst = 1'b0;
        ref_last = 1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.i_resp || bus.d_resp) saw = 1'b1;
        end
        chk("abort_no_resp", {255'b0, saw}, '0);
        run_set(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, '0, 0, f, n);
        chk("after_abort_resp_count", n, 1);
        model_update(1'b1, 1'b0, f);

        // Random traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            if (!ri && !rd && !wd) ri = 1'b1;
            ai = 32'h0000_2000 + 32'($urandom_range(0, 32'h1fff));
            ad = 32'h0001_0000 + 32'($urandom_range(0, 32'h7ff));
            for (int k = 0; k < 8; k++) wdat[k*32 +: 32] = $urandom();
            run_set(ri, rd, wd, ai, ad, wdat, int'($urandom_range(0, 3)), f, n);
            chk("rand_first_grant", f, model_first(ri, rd | wd));
            chk("rand_resp_count", n, int'(ri) + int'(rd | wd));
            model_update(ri, rd | wd, model_first(ri, rd | wd));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
